// File: rtl/pcm_to_i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_to_i2s_tx_pkg
//  Brief    : Shared default sizing constants for the PCM-to-I2S transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package pcm_to_i2s_tx_pkg;

    // Sample width shared with the rest of the audio datapath.
    localparam int NUMBER_OF_BITS = 8;

    // Default sizing for pcm_to_i2s_tx.
    localparam int c_SAMPLE_BITS  = NUMBER_OF_BITS;
    localparam int c_SLOT_BITS    = 16;
    localparam int c_BCLK_DIV     = 2;

endpackage : pcm_to_i2s_tx_pkg
`default_nettype wire

// File: rtl/pcm_to_i2s_tx_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clk_gen
//  Brief    : SCK divider. Toggles SCK every BCLK_DIV clk cycles and flags
//             the clk cycle in which SCK falls (the data shift event).
//  Revision : 1.0  initial release
// ============================================================================
module i2s_clk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_sck,
    output logic o_shift
);

    localparam int                 c_DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_sck;
    logic               w_term;

    assign w_term = (r_div == c_DIV_LAST);

    // Divider and SCK toggle; both parked at 0 while disabled.
    always_ff @(posedge clk) begin
        if (reset || !i_enable) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_term) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign o_sck   = r_sck;
    // Strobe is high in the cycle whose clock edge takes SCK from 1 to 0.
    assign o_shift = i_enable & w_term & r_sck;

endmodule : i2s_clk_gen
`default_nettype wire

// File: rtl/pcm_to_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pcm_to_i2s_tx
//  Brief    : Stereo PCM to I2S serialiser with a one-pair pending buffer,
//             underrun detection and a saturating underrun counter.
//  Revision : 1.0  initial release
// ============================================================================
module pcm_to_i2s_tx
    import pcm_to_i2s_tx_pkg::*;
#(
    parameter int SAMPLE_BITS = c_SAMPLE_BITS,
    parameter int SLOT_BITS   = c_SLOT_BITS,
    parameter int BCLK_DIV    = c_BCLK_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic [SAMPLE_BITS-1:0] in_left,
    input  logic [SAMPLE_BITS-1:0] in_right,
    output logic                   in_ready,
    output logic                   sck,
    output logic                   ws,
    output logic                   sd,
    output logic                   frame_start,
    output logic                   underrun,
    output logic [7:0]             underrun_count
);

    localparam int                 c_CNT_W    = $clog2(SLOT_BITS);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(SLOT_BITS - 1);

    // Pending pair; r_in_ready doubles as the "pending empty" flag.
    logic [SAMPLE_BITS-1:0] r_pend_l;
    logic [SAMPLE_BITS-1:0] r_pend_r;
    logic                   r_in_ready;

    // Serialiser state.
    logic [SAMPLE_BITS-1:0] r_sh_l;
    logic [SAMPLE_BITS-1:0] r_sh_r;
    logic [c_CNT_W-1:0]     r_bitcnt;
    logic                   r_ws;
    logic                   r_sd;
    logic                   r_first;
    logic                   r_frame_start;
    logic                   r_underrun;
    logic [7:0]             r_underrun_count;

    logic                   w_sck;
    logic                   w_shift;
    logic                   w_wrap;
    logic                   w_slot_start;
    logic                   w_frame_load;
    logic                   w_hs;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .o_sck    (w_sck),
        .o_shift  (w_shift)
    );

    // r_first marks the first shift event after enable, which always opens
    // a left slot regardless of where the bit counter was parked.
    assign w_wrap       = (r_bitcnt == c_BIT_LAST);
    assign w_slot_start = r_first | w_wrap;
    assign w_frame_load = w_shift & (r_first | (w_wrap & r_ws));
    assign w_hs         = in_valid & r_in_ready;

    // Handshake, frame loading and bit serialisation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_l         <= '0;
            r_pend_r         <= '0;
            r_in_ready       <= 1'b1;
            r_sh_l           <= '0;
            r_sh_r           <= '0;
            r_bitcnt         <= '0;
            r_ws             <= 1'b0;
            r_sd             <= 1'b0;
            r_first          <= 1'b1;
            r_frame_start    <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= 8'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            // The pending slot keeps accepting data even while disabled.
            if (w_hs) begin
                r_pend_l   <= in_left;
                r_pend_r   <= in_right;
                r_in_ready <= 1'b0;
            end

            if (!enable) begin
                r_bitcnt <= '0;
                r_ws     <= 1'b0;
                r_sd     <= 1'b0;
                r_first  <= 1'b1;
            end else if (w_shift) begin
                r_first  <= 1'b0;
                r_bitcnt <= w_slot_start ? '0 : (r_bitcnt + c_CNT_W'(1));
                if (w_slot_start) begin
                    // One-bit I2S delay: the ws-change bit is always 0.
                    r_sd <= 1'b0;
                    r_ws <= r_first ? 1'b0 : ~r_ws;
                    if (w_frame_load) begin
                        r_frame_start <= 1'b1;
                        if (!r_in_ready) begin
                            r_sh_l     <= r_pend_l;
                            r_sh_r     <= r_pend_r;
                            r_in_ready <= 1'b1;
                        end else begin
                            // Nothing queued: send silence. A handshake in
                            // this same cycle still lands in pending above.
                            r_sh_l     <= '0;
                            r_sh_r     <= '0;
                            r_underrun <= 1'b1;
                            if (r_underrun_count != 8'hFF) begin
                                r_underrun_count <= r_underrun_count + 8'd1;
                            end
                        end
                    end
                end else if (r_ws) begin
                    // Zeros shift in behind the sample, padding the slot.
                    r_sd   <= r_sh_r[SAMPLE_BITS-1];
                    r_sh_r <= {r_sh_r[SAMPLE_BITS-2:0], 1'b0};
                end else begin
                    r_sd   <= r_sh_l[SAMPLE_BITS-1];
                    r_sh_l <= {r_sh_l[SAMPLE_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign sck            = w_sck;
    assign ws             = r_ws;
    assign sd             = r_sd;
    assign frame_start    = r_frame_start;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule : pcm_to_i2s_tx
`default_nettype wire

// File: tb/tb_pcm_to_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcm_to_i2s_tx
//  Brief    : Self-checking bench for pcm_to_i2s_tx (8-bit samples, 16-bit
//             slots, BCLK_DIV=2) with a scoreboard of accepted pairs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcm_to_i2s_tx;

    typedef struct packed {
        logic [7:0] l;
        logic [7:0] r;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       in_valid;
    logic [7:0] in_left;
    logic [7:0] in_right;
    logic       in_ready;
    logic       sck;
    logic       ws;
    logic       sd;
    logic       frame_start;
    logic       underrun;
    logic [7:0] underrun_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard and monitor state.
    pair_t q[$];
    pair_t cur_exp;
    pair_t hs_pair;
    bit    rst_prev   = 1'b1;
    bit    en_prev    = 1'b0;
    bit    sck_prev   = 1'b0;
    bit    hs_prev    = 1'b0;
    bit    mon_active = 1'b0;
    bit    tail_ok    = 1'b1;
    int    mon_idx    = 0;
    int    frames_done = 0;
    int    exp_ucount = 0;
    int    un_seen    = 0;
    logic [7:0] lw, rw;

    pcm_to_i2s_tx #(
        .SAMPLE_BITS (8),
        .SLOT_BITS   (16),
        .BCLK_DIV    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_ready       (in_ready),
        .sck            (sck),
        .ws             (ws),
        .sd             (sd),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 3 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [7:0] l, input logic [7:0] r, output int hcyc);
        int n;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("send_accept_in_time", 32'(n < 1000), 32'd1);
        hcyc = cyc + 1;
        step();
    endtask

    task automatic wait_frames(input int n);
        int base;
        int t;
        base = frames_done;
        t = 0;
        while (frames_done < base + n && t < n * 128 + 300) begin
            step();
            t++;
        end
        chk("frames_completed", 32'(frames_done - base), 32'(n));
    endtask

    task automatic wait_idx(input int idx);
        int t;
        t = 0;
        while (!(mon_active && mon_idx == idx) && t < 600) begin
            step();
            t++;
        end
        chk("reach_bit_index", 32'(t < 600), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_underrun_count", 32'(underrun_count), 32'd0);
    endtask

    // Decodes the serial stream on each observed SCK fall and scores frames.
    always @(negedge clk) begin
        bit shift_seen;
        bit exp_un;
        if (rst_prev) begin
            q.delete();
            mon_active = 1'b0;
            exp_ucount = 0;
            un_seen    = 0;
        end else begin
            shift_seen = en_prev && sck_prev && !sck;
            if (!en_prev) mon_active = 1'b0;
            if (shift_seen && frame_start) begin
                chk("load_sd", 32'(sd), 32'd0);
                chk("load_ws", 32'(ws), 32'd0);
                if (q.size() > 0) begin
                    cur_exp = q.pop_front();
                    exp_un  = 1'b0;
                end else begin
                    cur_exp = '0;
                    exp_un  = 1'b1;
                end
                chk("underrun_pulse", 32'(underrun), 32'(exp_un));
                if (underrun) un_seen++;
                if (exp_un && exp_ucount != 255) exp_ucount++;
                chk("underrun_count", 32'(underrun_count), 32'(exp_ucount));
                mon_active = 1'b1;
                mon_idx    = 0;
                lw         = '0;
                rw         = '0;
                tail_ok    = 1'b1;
            end else begin
                chk("no_stray_pulse", 32'({frame_start, underrun}), 32'd0);
                if (shift_seen && mon_active) begin
                    mon_idx++;
                    if (mon_idx >= 1 && mon_idx <= 8) lw = {lw[6:0], sd};
                    else if (mon_idx >= 17 && mon_idx <= 24) rw = {rw[6:0], sd};
                    else if (sd !== 1'b0) tail_ok = 1'b0;
                    if (ws !== ((mon_idx >= 16) ? 1'b1 : 1'b0)) tail_ok = 1'b0;
                    if (mon_idx == 31) begin
                        chk("left_sample", 32'(lw), 32'(cur_exp.l));
                        chk("right_sample", 32'(rw), 32'(cur_exp.r));
                        chk("slot_padding_ws", 32'(tail_ok), 32'd1);
                        frames_done++;
                        mon_active = 1'b0;
                    end
                end
            end
            if (hs_prev) q.push_back(hs_pair);
        end
        rst_prev = reset;
        en_prev  = enable;
        sck_prev = sck;
        hs_prev  = in_valid && in_ready && !reset;
        hs_pair  = '{l: in_left, r: in_right};
    end

    initial begin
        int h0, h1, h2, h3;
        int t, r1, r2;
        bit prev;

        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b1;
        in_left  = 8'hFF;
        in_right = 8'hFF;
        repeat (5) step();
        check_reset_outputs();
        in_valid = 1'b0;
        reset    = 1'b0;
        step();

        // Basic pair A5/3C, loaded while disabled, sent once enabled.
        send(8'hA5, 8'h3C, h0);
        in_valid = 1'b0;
        chk("ready_low_after_accept", 32'(in_ready), 32'd0);
        enable = 1'b1;
        prev = 1'b0; t = 0;
        while (!(sck && !prev) && t < 50) begin prev = sck; step(); t++; end
        r1 = cyc;
        prev = sck; step(); t = 0;
        while (!(sck && !prev) && t < 50) begin prev = sck; step(); t++; end
        r2 = cyc;
        chk("sck_period", 32'(r2 - r1), 32'd4);
        wait_frames(2);

        // Back-to-back pairs with in_valid held high.
        send(8'h11, 8'h22, h1);
        send(8'h80, 8'h7F, h2);
        send(8'h01, 8'hFE, h3);
        in_valid = 1'b0;
        chk("handshake_spacing", 32'(h3 - h2), 32'd128);
        wait_frames(2);

        // Underruns from a clean reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_frames(3);
        chk("underrun_count_3", 32'(underrun_count), 32'd3);
        chk("underrun_pulses_3", 32'(un_seen), 32'd3);
        wait_frames(300);
        chk("underrun_count_sat", 32'(underrun_count), 32'd255);

        // Reset in the middle of the right slot.
        send(8'h77, 8'h88, h0);
        in_valid = 1'b0;
        wait_idx(22);
        reset = 1'b1;
        step();
        check_reset_outputs();
        reset = 1'b0;
        send(8'h9A, 8'hBC, h0);
        in_valid = 1'b0;
        wait_frames(1);

        // Enable dropped mid-frame, pair accepted while idle.
        wait_idx(10);
        enable = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("idle_outputs", 32'({sck, ws, sd}), 32'd0);
            step();
        end
        send(8'hC3, 8'h5A, h0);
        in_valid = 1'b0;
        chk("idle_accept_ready", 32'(in_ready), 32'd0);
        repeat (5) step();
        chk("idle_sck", 32'(sck), 32'd0);
        enable = 1'b1;
        wait_frames(1);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pcm_to_i2s_tx
`default_nettype wire
